cl_frame_capture: RTL and testbench

Frame capture front end: takes the deserialized CameraLink tap bus and FVAL/LVAL/DVAL strobes, already in the system clock domain, and produces the pixel-word stream consumed by the DMA packing stage. It gates capture to whole frames, selects 24-bit (base) or 48-bit (medium) tap mode, and clips lines to a configured width. It emits a frame-reset pulse before each frame and an end-of-frame strobe after it, and it keeps line/frame counters and sticky geometry-error flags for software.

---
 rtl/cl_pkg.sv | 16 +
 rtl/cl_frame_capture_if.sv | 27 ++
 rtl/cl_sig_edge.sv | 32 +++
 rtl/cl_frame_capture.sv | 216 +++++++++++++++++++++
 tb/tb_cl_frame_capture.sv | 336 +++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/cl_pkg.sv
// Shared definitions for the CameraLink frame capture front end.
//   cl_state_t : capture state machine encoding
//   CL_BASE_W  : beat width in base (24-bit, ports A..C) mode
//   CL_MED_W   : beat width in medium (48-bit, ports A..F) mode
package cl_pkg;
  localparam int CL_BASE_W = 24;
  localparam int CL_MED_W  = 48;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SYNC,
    ST_WAIT_FV,
    ST_ACTIVE,
    ST_END
  } cl_state_t;
endpackage

// File: rtl/cl_frame_capture_if.sv
// Bus bundles for the capture front end.
//   cl_link_if : deserialized tap bus plus FVAL/LVAL/DVAL strobes
//                (master = camera side, slave = capture block)
//   cl_pix_if  : pixel-word stream toward the DMA packer plus frame markers
//                (master = capture block, slave = consumer)
interface cl_link_if;
  import cl_pkg::*;
  logic [CL_MED_W-1:0] cl_data;
  logic                cl_fval;
  logic                cl_lval;
  logic                cl_dval;

  modport master (output cl_data, cl_fval, cl_lval, cl_dval);
  modport slave  (input  cl_data, cl_fval, cl_lval, cl_dval);
endinterface

interface cl_pix_if;
  import cl_pkg::*;
  logic [CL_MED_W-1:0] pix_data;
  logic                pix_vld;
  logic                pix_end;
  logic                pix_sel;
  logic                frame_rst;

  modport master (output pix_data, pix_vld, pix_end, pix_sel, frame_rst);
  modport slave  (input  pix_data, pix_vld, pix_end, pix_sel, frame_rst);
endinterface

// File: rtl/cl_sig_edge.sv
// Two-stage register for a group of strobes with edge detection.
//   clk_i, rst_i : clock, synchronous active-high reset
//   sig_i        : raw strobes
//   s1_o         : strobes after the first register stage
//   rise_o/fall_o: per-bit edges of s1 measured against the second stage
module cl_sig_edge #(
  parameter int N = 3
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic [N-1:0] sig_i,
  output logic [N-1:0] s1_o,
  output logic [N-1:0] rise_o,
  output logic [N-1:0] fall_o
);
  logic [N-1:0] s1_q;
  logic [N-1:0] s2_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      s1_q <= '0;
      s2_q <= '0;
    end else begin
      s1_q <= sig_i;
      s2_q <= s1_q;
    end
  end

  assign s1_o   = s1_q;
  assign rise_o = s1_q & ~s2_q;
  assign fall_o = ~s1_q & s2_q;
endmodule

// File: rtl/cl_frame_capture.sv
// CameraLink frame capture front end. Gates capture to whole frames, selects
// 24/48-bit beats, clips lines to the configured width, and keeps line/frame
// counters plus sticky geometry error flags.
//   sys_clk, sys_rst        : clock, synchronous active-high reset
//   cl  (cl_link_if.slave)  : tap bus and FVAL/LVAL/DVAL
//   pix (cl_pix_if.master)  : pix_data/pix_vld/pix_end/pix_sel/frame_rst
//   cfg_arm                 : one-cycle start pulse, clears error flags
//   cfg_continuous          : re-arm after every frame
//   cfg_medium              : 1 = 48-bit beats
//   cfg_width, cfg_height   : beats per line, lines per frame
//   busy                    : state machine not idle
//   line_cnt, frame_cnt     : lines in current/last frame, completed frames
//   err_short_line, err_long_line, err_height : sticky geometry errors
module cl_frame_capture
  import cl_pkg::*;
#(
  parameter int WIDTH_W  = 16,
  parameter int HEIGHT_W = 16
) (
  input  logic                sys_clk,
  input  logic                sys_rst,
  cl_link_if.slave            cl,
  cl_pix_if.master            pix,
  input  logic                cfg_arm,
  input  logic                cfg_continuous,
  input  logic                cfg_medium,
  input  logic [WIDTH_W-1:0]  cfg_width,
  input  logic [HEIGHT_W-1:0] cfg_height,
  output logic                busy,
  output logic [HEIGHT_W-1:0] line_cnt,
  output logic [15:0]         frame_cnt,
  output logic                err_short_line,
  output logic                err_long_line,
  output logic                err_height
);

  // Line counter holds at all-ones instead of wrapping.
  function automatic logic [HEIGHT_W-1:0] sat_inc_line(input logic [HEIGHT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  // ---- s1/s2: input registers and strobe edges ----
  logic [CL_MED_W-1:0] data_s1_q;
  logic [2:0]          strb_s1;
  logic [2:0]          strb_rise;
  logic [2:0]          strb_fall;

  always_ff @(posedge sys_clk) begin
    data_s1_q <= cl.cl_data;
  end

  // Bit order: 0 = FVAL, 1 = LVAL, 2 = DVAL.
  cl_sig_edge #(.N(3)) u_strb_edge (
    .clk_i  (sys_clk),
    .rst_i  (sys_rst),
    .sig_i  ({cl.cl_dval, cl.cl_lval, cl.cl_fval}),
    .s1_o   (strb_s1),
    .rise_o (strb_rise),
    .fall_o (strb_fall)
  );

  logic fval_s1;
  logic beat_s1;
  logic fv_rise;
  logic fv_fall;
  logic lv_fall;
  logic unused_edges;

  assign fval_s1      = strb_s1[0];
  assign beat_s1      = &strb_s1;
  assign fv_rise      = strb_rise[0];
  assign fv_fall      = strb_fall[0];
  assign lv_fall      = strb_fall[1];
  assign unused_edges = ^{strb_rise[2:1], strb_fall[2]};

  // ---- FSM and counters; all outputs registered from here ----
  cl_state_t           state_q,      state_d;
  logic [WIDTH_W-1:0]  width_q,      width_d;
  logic [HEIGHT_W-1:0] height_q,     height_d;
  logic [WIDTH_W-1:0]  beat_cnt_q,   beat_cnt_d;
  logic [HEIGHT_W-1:0] line_cnt_q,   line_cnt_d;
  logic [15:0]         frame_cnt_q,  frame_cnt_d;
  logic                sel_q,        sel_d;
  logic                err_short_q,  err_short_d;
  logic                err_long_q,   err_long_d;
  logic                err_height_q, err_height_d;
  logic [CL_MED_W-1:0] pix_data_q,   pix_data_d;
  logic                pix_vld_q,    pix_vld_d;
  logic                pix_end_q,    pix_end_d;
  logic                frame_rst_q,  frame_rst_d;

  always_comb begin
    state_d      = state_q;
    width_d      = width_q;
    height_d     = height_q;
    beat_cnt_d   = beat_cnt_q;
    line_cnt_d   = line_cnt_q;
    frame_cnt_d  = frame_cnt_q;
    sel_d        = sel_q;
    err_short_d  = err_short_q;
    err_long_d   = err_long_q;
    err_height_d = err_height_q;
    pix_data_d   = pix_data_q;
    pix_vld_d    = 1'b0;
    pix_end_d    = 1'b0;
    frame_rst_d  = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (cfg_arm) begin
          err_short_d  = 1'b0;
          err_long_d   = 1'b0;
          err_height_d = 1'b0;
          state_d      = ST_SYNC;
        end
      end

      // Never start mid-frame: wait for FVAL low first.
      ST_SYNC: begin
        if (!fval_s1) state_d = ST_WAIT_FV;
      end

      // A beat arriving together with the FVAL rise is not captured; the
      // first capturable beat is one cycle later, after frame_rst.
      ST_WAIT_FV: begin
        if (fv_rise) begin
          frame_rst_d = 1'b1;
          sel_d       = cfg_medium;
          width_d     = cfg_width;
          height_d    = cfg_height;
          line_cnt_d  = '0;
          beat_cnt_d  = '0;
          state_d     = ST_ACTIVE;
        end
      end

      ST_ACTIVE: begin
        if (beat_s1) begin
          if (beat_cnt_q < width_q) begin
            pix_vld_d  = 1'b1;
            pix_data_d = sel_q ? data_s1_q
                               : {{(CL_MED_W-CL_BASE_W){1'b0}}, data_s1_q[CL_BASE_W-1:0]};
            beat_cnt_d = beat_cnt_q + 1'b1;
          end else begin
            err_long_d = 1'b1;
          end
        end
        // A line ending in the same cycle as the frame is still counted here.
        if (lv_fall) begin
          if (beat_cnt_q < width_q) err_short_d = 1'b1;
          line_cnt_d = sat_inc_line(line_cnt_q);
          beat_cnt_d = '0;
        end
        // pix_end is raised on the transition so it lines up with END.
        if (fv_fall) begin
          pix_end_d = 1'b1;
          state_d   = ST_END;
        end
      end

      ST_END: begin
        if (line_cnt_q != height_q) err_height_d = 1'b1;
        frame_cnt_d = frame_cnt_q + 16'd1;
        state_d     = cfg_continuous ? ST_WAIT_FV : ST_IDLE;
      end

      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state_q      <= ST_IDLE;
      width_q      <= '0;
      height_q     <= '0;
      beat_cnt_q   <= '0;
      line_cnt_q   <= '0;
      frame_cnt_q  <= '0;
      sel_q        <= 1'b0;
      err_short_q  <= 1'b0;
      err_long_q   <= 1'b0;
      err_height_q <= 1'b0;
      pix_data_q   <= '0;
      pix_vld_q    <= 1'b0;
      pix_end_q    <= 1'b0;
      frame_rst_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      width_q      <= width_d;
      height_q     <= height_d;
      beat_cnt_q   <= beat_cnt_d;
      line_cnt_q   <= line_cnt_d;
      frame_cnt_q  <= frame_cnt_d;
      sel_q        <= sel_d;
      err_short_q  <= err_short_d;
      err_long_q   <= err_long_d;
      err_height_q <= err_height_d;
      pix_data_q   <= pix_data_d;
      pix_vld_q    <= pix_vld_d;
      pix_end_q    <= pix_end_d;
      frame_rst_q  <= frame_rst_d;
    end
  end

  assign pix.pix_data    = pix_data_q;
  assign pix.pix_vld     = pix_vld_q;
  assign pix.pix_end     = pix_end_q;
  assign pix.pix_sel     = sel_q;
  assign pix.frame_rst   = frame_rst_q;
  assign busy            = (state_q != ST_IDLE);
  assign line_cnt        = line_cnt_q;
  assign frame_cnt       = frame_cnt_q;
  assign err_short_line  = err_short_q;
  assign err_long_line   = err_long_q;
  assign err_height      = err_height_q;
endmodule

// File: tb/tb_cl_frame_capture.sv
// Scoreboard bench for cl_frame_capture: every captured beat is queued with
// its expected data and drive cycle, and popped when pix_vld appears.
module tb_cl_frame_capture;
  localparam int WIDTH_W  = 16;
  localparam int HEIGHT_W = 16;

  logic sys_clk = 1'b0;
  logic sys_rst;
  always #5 sys_clk = ~sys_clk;

  cl_link_if link ();
  cl_pix_if  pix ();

  logic                cfg_arm, cfg_continuous, cfg_medium;
  logic [WIDTH_W-1:0]  cfg_width;
  logic [HEIGHT_W-1:0] cfg_height;
  logic                busy;
  logic [HEIGHT_W-1:0] line_cnt;
  logic [15:0]         frame_cnt;
  logic                err_short_line, err_long_line, err_height;

  cl_frame_capture #(.WIDTH_W(WIDTH_W), .HEIGHT_W(HEIGHT_W)) dut (
    .sys_clk        (sys_clk),
    .sys_rst        (sys_rst),
    .cl             (link),
    .pix            (pix),
    .cfg_arm        (cfg_arm),
    .cfg_continuous (cfg_continuous),
    .cfg_medium     (cfg_medium),
    .cfg_width      (cfg_width),
    .cfg_height     (cfg_height),
    .busy           (busy),
    .line_cnt       (line_cnt),
    .frame_cnt      (frame_cnt),
    .err_short_line (err_short_line),
    .err_long_line  (err_long_line),
    .err_height     (err_height)
  );

  typedef struct {
    logic [47:0] data;
    int          cyc;
  } beat_t;

  beat_t       sb[$];
  int          n_chk = 0;
  int          n_fail = 0;
  int          cyc = 0;
  int          fv_cyc = 0;
  int          fe_cyc = 0;
  int          n_vld = 0;
  int          n_frst = 0;
  int          n_end = 0;
  bit          in_frame = 0;
  bit          exp_sel = 0;
  bit          fc_pending = 0;
  logic [15:0] exp_fc = 16'd0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Output monitor, sampled on the falling edge.
  task automatic sample();
    beat_t e;
    if (pix.pix_vld === 1'b1) begin
      n_vld++;
      check("vld_inside_frame", in_frame, 1'b1);
      check("pix_sel_during_frame", pix.pix_sel, exp_sel);
      check("sb_has_entry", (sb.size() > 0), 1'b1);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        check("pix_data", pix.pix_data, e.data);
        check("vld_latency", cyc - e.cyc, 2);
      end
    end
    if (pix.frame_rst === 1'b1) begin
      n_frst++;
      in_frame = 1'b1;
      check("frst_latency", cyc - fv_cyc, 2);
    end
    if (fc_pending) begin
      check("frame_cnt_step", frame_cnt, exp_fc);
      fc_pending = 1'b0;
    end
    if (pix.pix_end === 1'b1) begin
      n_end++;
      check("end_latency", cyc - fe_cyc, 2);
      check("end_exclusive", {pix.pix_vld, pix.frame_rst}, 2'b00);
      in_frame   = 1'b0;
      exp_fc     = exp_fc + 16'd1;
      fc_pending = 1'b1;
    end
    if (sys_rst === 1'b1) begin
      sb.delete();
      in_frame   = 1'b0;
      exp_fc     = 16'd0;
      fc_pending = 1'b0;
    end
  endtask

  task automatic tick();
    @(negedge sys_clk);
    sample();
    @(posedge sys_clk);
    cyc++;
    #1;
  endtask

  task automatic arm();
    cfg_arm = 1'b1;
    tick();
    cfg_arm = 1'b0;
  endtask

  // One line of nbeats valid beats with a DVAL stall after the first beat;
  // the first 'keep' beats are expected at the output.
  task automatic drive_line(input int nbeats, input int keep, input bit med, input bit joint);
    logic [63:0] r;
    logic [47:0] d;
    beat_t       e;
    for (int b = 0; b < nbeats; b++) begin
      r = {$urandom, $urandom};
      d = r[47:0];
      link.cl_lval = 1'b1;
      link.cl_dval = 1'b1;
      link.cl_data = d;
      if (b < keep) begin
        e.data = med ? d : {24'h0, d[23:0]};
        e.cyc  = cyc;
        sb.push_back(e);
      end
      tick();
      if (b == 0 && nbeats > 1) begin
        link.cl_dval = 1'b0;
        link.cl_data = ~d;
        tick();
      end
    end
    link.cl_lval = 1'b0;
    link.cl_dval = 1'b0;
    if (!joint) begin
      tick();
      tick();
    end
  endtask

  task automatic drive_frame(input int nlines, input int nbeats, input int keep,
                             input bit med, input bit joint, input bit scramble);
    logic                sv_med;
    logic [WIDTH_W-1:0]  sv_w;
    logic [HEIGHT_W-1:0] sv_h;
    sv_med = cfg_medium;
    sv_w   = cfg_width;
    sv_h   = cfg_height;
    link.cl_fval = 1'b1;
    fv_cyc = cyc;
    tick();
    tick();
    for (int l = 0; l < nlines; l++) begin
      drive_line(nbeats, keep, med, joint && (l == nlines - 1));
      if (scramble && l == 0) begin
        cfg_medium = ~cfg_medium;
        cfg_width  = cfg_width + 16'd3;
        cfg_height = cfg_height + 16'd5;
      end
    end
    link.cl_fval = 1'b0;
    fe_cyc = cyc;
    repeat (4) tick();
    cfg_medium = sv_med;
    cfg_width  = sv_w;
    cfg_height = sv_h;
  endtask

  int v0, f0, e0;
  logic [63:0] rr;

  initial begin
    sys_rst        = 1'b1;
    link.cl_data   = '0;
    link.cl_fval   = 1'b0;
    link.cl_lval   = 1'b0;
    link.cl_dval   = 1'b0;
    cfg_arm        = 1'b0;
    cfg_continuous = 1'b0;
    cfg_medium     = 1'b0;
    cfg_width      = 16'd8;
    cfg_height     = 16'd4;
    repeat (3) tick();

    // Reset state
    check("rst_pix_data",  pix.pix_data, 48'h0);
    check("rst_pix_vld",   pix.pix_vld, 1'b0);
    check("rst_pix_end",   pix.pix_end, 1'b0);
    check("rst_pix_sel",   pix.pix_sel, 1'b0);
    check("rst_frame_rst", pix.frame_rst, 1'b0);
    check("rst_busy",      busy, 1'b0);
    check("rst_line_cnt",  line_cnt, 16'd0);
    check("rst_frame_cnt", frame_cnt, 16'd0);
    check("rst_err_short", err_short_line, 1'b0);
    check("rst_err_long",  err_long_line, 1'b0);
    check("rst_err_height", err_height, 1'b0);
    sys_rst = 1'b0;
    tick();

    // Arm during a frame already in progress, then a clean base-mode frame
    exp_sel = 1'b0;
    link.cl_fval = 1'b1;
    tick();
    tick();
    arm();
    check("busy_after_arm", busy, 1'b1);
    drive_line(4, 0, 1'b0, 1'b0);
    link.cl_fval = 1'b0;
    repeat (4) tick();
    check("partial_no_frst", n_frst, 0);
    drive_frame(4, 8, 8, 1'b0, 1'b0, 1'b0);
    check("base_vld_count", n_vld, 32);
    check("base_frst_count", n_frst, 1);
    check("base_end_count", n_end, 1);
    check("base_line_cnt", line_cnt, 16'd4);
    check("base_frame_cnt", frame_cnt, 16'd1);
    check("base_err", {err_short_line, err_long_line, err_height}, 3'b000);
    check("base_idle", busy, 1'b0);
    check("base_sb_empty", sb.size(), 0);

    // Medium mode, 6-beat lines clipped to 4; cfg changes mid-frame ignored
    cfg_medium = 1'b1;
    cfg_width  = 16'd4;
    cfg_height = 16'd2;
    exp_sel    = 1'b1;
    v0 = n_vld;
    arm();
    drive_frame(2, 6, 4, 1'b1, 1'b0, 1'b1);
    check("med_vld_count", n_vld - v0, 8);
    check("med_err_long", err_long_line, 1'b1);
    check("med_err_short", err_short_line, 1'b0);
    check("med_err_height", err_height, 1'b0);
    check("med_line_cnt", line_cnt, 16'd2);
    check("med_pix_sel", pix.pix_sel, 1'b1);
    check("med_frame_cnt", frame_cnt, 16'd2);

    // Short lines and short frame, last line ends together with FVAL
    cfg_medium = 1'b0;
    cfg_width  = 16'd4;
    cfg_height = 16'd4;
    exp_sel    = 1'b0;
    arm();
    check("arm_clears_long", err_long_line, 1'b0);
    drive_frame(3, 3, 3, 1'b0, 1'b1, 1'b0);
    check("short_err_short", err_short_line, 1'b1);
    check("short_err_height", err_height, 1'b1);
    check("short_err_long", err_long_line, 1'b0);
    check("short_line_cnt", line_cnt, 16'd3);
    arm();
    check("rearm_clears_short", err_short_line, 1'b0);
    check("rearm_clears_height", err_height, 1'b0);

    // Zero width drops every beat
    cfg_width  = 16'd0;
    cfg_height = 16'd1;
    v0 = n_vld;
    drive_frame(1, 2, 0, 1'b0, 1'b0, 1'b0);
    check("zw_no_vld", n_vld - v0, 0);
    check("zw_err_long", err_long_line, 1'b1);
    check("zw_err_short", err_short_line, 1'b0);
    check("zw_err_height", err_height, 1'b0);
    check("zw_line_cnt", line_cnt, 16'd1);

    // Continuous mode, three back-to-back frames, frame counter wraps
    force dut.frame_cnt_q = 16'hFFFF;
    tick();
    release dut.frame_cnt_q;
    exp_fc         = 16'hFFFF;
    cfg_continuous = 1'b1;
    cfg_width      = 16'd2;
    cfg_height     = 16'd2;
    f0 = n_frst;
    e0 = n_end;
    arm();
    for (int k = 0; k < 3; k++) drive_frame(2, 2, 2, 1'b0, 1'b0, 1'b0);
    check("cont_frst_count", n_frst - f0, 3);
    check("cont_end_count", n_end - e0, 3);
    check("cont_frame_cnt_wrap", frame_cnt, 16'd2);
    check("cont_busy", busy, 1'b1);
    check("cont_err", {err_short_line, err_long_line, err_height}, 3'b000);

    // Reset in the middle of a line
    cfg_continuous = 1'b0;
    link.cl_fval = 1'b1;
    fv_cyc = cyc;
    tick();
    tick();
    for (int b = 0; b < 3; b++) begin
      beat_t e;
      rr = {$urandom, $urandom};
      link.cl_lval = 1'b1;
      link.cl_dval = 1'b1;
      link.cl_data = rr[47:0];
      e.data = {24'h0, rr[23:0]};
      e.cyc  = cyc;
      sb.push_back(e);
      tick();
    end
    sys_rst = 1'b1;
    tick();
    sys_rst = 1'b0;
    check("mrst_pix_vld", pix.pix_vld, 1'b0);
    check("mrst_busy", busy, 1'b0);
    check("mrst_line_cnt", line_cnt, 16'd0);
    check("mrst_frame_cnt", frame_cnt, 16'd0);
    check("mrst_pix_end", pix.pix_end, 1'b0);
    v0 = n_vld;
    e0 = n_end;
    tick();
    tick();
    link.cl_lval = 1'b0;
    link.cl_dval = 1'b0;
    tick();
    link.cl_fval = 1'b0;
    repeat (4) tick();
    drive_frame(2, 3, 0, 1'b0, 1'b0, 1'b0);
    check("mrst_no_vld", n_vld - v0, 0);
    check("mrst_no_end", n_end - e0, 0);
    check("mrst_still_idle", busy, 1'b0);
    check("final_sb_empty", sb.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
